// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner: row strobe, per-key press/release debounce,
// 4-deep key-code FIFO and a two-register read port (key data, status).
module keypad_scan_controller #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic [3:0] address,
  input  logic       readEnable,
  output logic [7:0] dout
);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] div;
  logic        tick;
  logic [1:0]  r;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [3:0]  key_code;
  logic        cand_valid;
  logic [1:0]  cand_col;
  logic [3:0]  cand_code;
  logic        push;

  logic [3:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        ovf;
  logic        nonempty;
  logic        data_rd;
  logic        status_rd;
  logic        pop;
  logic        do_push;
  logic        overflow_evt;

  assign tick     = (div == 16'(SCAN_DIV - 1));
  assign rows     = ~(4'b0001 << r);
  assign cnt_next = cnt + 4'd1;

  // Exactly one low column is a key; none or several (ghosting) is no key.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand_valid = 1'b0;
    cand_col   = 2'd0;
    case (cols)
      4'b1110: begin cand_valid = 1'b1; cand_col = 2'd0; end
      4'b1101: begin cand_valid = 1'b1; cand_col = 2'd1; end
      4'b1011: begin cand_valid = 1'b1; cand_col = 2'd2; end
      4'b0111: begin cand_valid = 1'b1; cand_col = 2'd3; end
      default: begin cand_valid = 1'b0; cand_col = 2'd0; end
    endcase
  end

  assign cand_code = {r, cand_col};

  assign push = tick && (state == PRESS_DB) && cand_valid &&
                (cand_code == key_code) && (cnt_next == 4'(DEBOUNCE_N));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      r        <= 2'd0;
      state    <= SCAN;
      cnt      <= 4'd0;
      key_code <= 4'd0;
    end else begin
      div <= tick ? 16'd0 : div + 16'd1;
      if (tick) begin
        case (state)
          SCAN: begin
            if (cand_valid) begin
              key_code <= cand_code;
              cnt      <= 4'd0;
              state    <= PRESS_DB;
            end else begin
              r <= r + 2'd1;
            end
          end
          PRESS_DB: begin
            if (cand_valid && (cand_code == key_code)) begin
              cnt <= cnt_next;
              if (cnt_next == 4'(DEBOUNCE_N)) state <= HELD;
            end else begin
              state <= SCAN;
              r     <= r + 2'd1;
            end
          end
          HELD: begin
            // Any key on the frozen row keeps the hold; no repeat pushes.
            if (!cand_valid) begin
              cnt   <= 4'd0;
              state <= RELEASE_DB;
            end
          end
          RELEASE_DB: begin
            if (cand_valid) begin
              state <= HELD;
            end else if (cnt_next == 4'(DEBOUNCE_N)) begin
              state <= SCAN;
              r     <= r + 2'd1;
            end else begin
              cnt <= cnt_next;
            end
          end
        endcase
      end
    end
  end

  assign nonempty     = (count != 3'd0);
  assign data_rd      = readEnable && (address == 4'd0);
  assign status_rd    = readEnable && (address == 4'd1);
  assign pop          = data_rd && nonempty;
  assign do_push      = push && ((count != 3'd4) || pop);
  assign overflow_evt = push && (count == 3'd4) && !pop;

  // NOTE: the FIFO storage is not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      ovf    <= 1'b0;
      dout   <= 8'h00;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      if (do_push && !pop)      count <= count + 3'd1;
      else if (pop && !do_push) count <= count - 3'd1;

      // A drop in the same cycle as a status read keeps the flag set.
      if (overflow_evt)   ovf <= 1'b1;
      else if (status_rd) ovf <= 1'b0;

      if (data_rd)
        dout <= nonempty ? {1'b1, 3'b000, mem[rd_ptr]} : 8'h00;
      else if (status_rd)
        dout <= {ovf, 2'b00, state, count};
      else
        dout <= 8'h00;
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Directed bench for keypad_scan_controller with SCAN_DIV=4, DEBOUNCE_N=2:
// scan order, debounce, ghosting, FIFO overflow and push/pop corner cases.
module tb_keypad_scan_controller;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols = 4'hF;
  logic [3:0] address = 4'd0;
  logic       readEnable = 1'b0;
  logic [7:0] dout;

  int assertions = 0;
  int failures   = 0;
  int ph;

  keypad_scan_controller #(
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE_N(DEBOUNCE_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .address   (address),
    .readEnable(readEnable),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  // Expected divider phase: a tick lands on the edge where ph == SCAN_DIV-1.
  always @(posedge clk) begin
    if (reset) ph <= 0;
    else       ph <= (ph == SCAN_DIV - 1) ? 0 : ph + 1;
  end

  function automatic logic [3:0] row_pat(input int row);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << row);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset      = 1'b1;
    cols       = 4'hF;
    readEnable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff ph == SCAN_DIV - 1);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    readEnable = 1'b1;
    address    = a;
    @(posedge clk);
    @(negedge clk);
    readEnable = 1'b0;
    address    = 4'd0;
    d          = dout;
  endtask

  task automatic goto_row(input int row);
    for (int i = 0; i < 8 && rows !== row_pat(row); i++) wait_ticks(1);
    assertions++;
    if (rows !== row_pat(row)) begin
      $display("FAIL goto_row: rows=%b required=%b", rows, row_pat(row));
      failures++;
    end
  endtask

  task automatic press_key(input int row, input int col);
    goto_row(row);
    cols = row_pat(col);
    wait_ticks(DEBOUNCE_N + 1);
    cols = 4'hF;
    wait_ticks(DEBOUNCE_N + 1);
  endtask

  // Press a key and issue a read on exactly the clock edge that accepts it.
  task automatic press_read(input int row, input int col, input logic [3:0] a,
                            output logic [7:0] d);
    goto_row(row);
    cols = row_pat(col);
    wait_ticks(DEBOUNCE_N);
    for (int i = 0; i < 8 && ph != SCAN_DIV - 1; i++) @(negedge clk);
    bus_read(a, d);
    cols = 4'hF;
    wait_ticks(DEBOUNCE_N + 1);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    @(negedge clk);
    reset      = 1'b1;
    readEnable = 1'b1;
    address    = 4'd1;
    repeat (2) @(negedge clk);
    assertions++;
    if (dout !== 8'h00) begin
      $display("FAIL reset_dout: got %h want 00", dout); failures++;
    end
    assertions++;
    if (rows !== 4'b1110) begin
      $display("FAIL reset_rows: got %b want 1110", rows); failures++;
    end
    readEnable = 1'b0;
    reset      = 1'b0;
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL reset_status: got %h want 00", d); failures++;
    end
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL reset_data: got %h want 00", d); failures++;
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] exp_rows [5];
    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      assertions++;
      if (rows !== exp_rows[k / 4]) begin
        $display("FAIL scan_order[%0d]: got %b want %b", k, rows, exp_rows[k / 4]);
        failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    logic [7:0] d;
    reset_dut();
    wait_ticks(1);
    assertions++;
    if (rows !== 4'b1101) begin
      $display("FAIL press_row: got %b want 1101", rows); failures++;
    end
    cols = 4'b1011;
    wait_ticks(3);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h11) begin
      $display("FAIL press_held_status: got %h want 11", d); failures++;
    end
    wait_ticks(3);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h11) begin
      $display("FAIL press_no_repeat: got %h want 11", d); failures++;
    end
    cols = 4'hF;
    wait_ticks(3);
    assertions++;
    if (rows !== 4'b1011) begin
      $display("FAIL release_row: got %b want 1011", rows); failures++;
    end
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h86) begin
      $display("FAIL press_data: got %h want 86", d); failures++;
    end
    @(negedge clk);
    assertions++;
    if (dout !== 8'h00) begin
      $display("FAIL idle_dout: got %h want 00", dout); failures++;
    end
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL press_empty: got %h want 00", d); failures++;
    end
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL press_final_status: got %h want 00", d); failures++;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] d;
    reset_dut();
    cols = 4'b1101;
    wait_ticks(1);
    cols = 4'hF;
    wait_ticks(1);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL bounce_glitch_status: got %h want 00", d); failures++;
    end
    cols = 4'b1101;
    wait_ticks(3);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h11) begin
      $display("FAIL bounce_held_status: got %h want 11", d); failures++;
    end
    cols = 4'hF;
    wait_ticks(3);
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h85) begin
      $display("FAIL bounce_data: got %h want 85", d); failures++;
    end
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL bounce_empty: got %h want 00", d); failures++;
    end
  endtask

  task automatic test_ghost();
    logic [7:0] d;
    reset_dut();
    cols = 4'b1100;
    for (int t = 1; t <= 8; t++) begin
      wait_ticks(1);
      assertions++;
      if (rows !== row_pat(t % 4)) begin
        $display("FAIL ghost_rows[%0d]: got %b want %b", t, rows, row_pat(t % 4));
        failures++;
      end
    end
    cols = 4'hF;
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL ghost_status: got %h want 00", d); failures++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] exp_data [5];
    exp_data = '{8'h80, 8'h85, 8'h8A, 8'h8F, 8'h00};
    reset_dut();
    press_key(0, 0);
    press_key(1, 1);
    press_key(2, 2);
    press_key(3, 3);
    press_key(0, 1);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h84) begin
      $display("FAIL ovf_status: got %h want 84", d); failures++;
    end
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h04) begin
      $display("FAIL ovf_cleared: got %h want 04", d); failures++;
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(4'd0, d);
      assertions++;
      if (d !== exp_data[i]) begin
        $display("FAIL ovf_data[%0d]: got %h want %h", i, d, exp_data[i]); failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] exp_data [4];
    exp_data = '{8'h85, 8'h8A, 8'h8F, 8'h82};
    reset_dut();
    press_key(0, 0);
    press_key(1, 1);
    press_key(2, 2);
    press_key(3, 3);
    press_read(0, 2, 4'd0, d);
    assertions++;
    if (d !== 8'h80) begin
      $display("FAIL pushpop_data: got %h want 80", d); failures++;
    end
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h04) begin
      $display("FAIL pushpop_status: got %h want 04", d); failures++;
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'd0, d);
      assertions++;
      if (d !== exp_data[i]) begin
        $display("FAIL pushpop_drain[%0d]: got %h want %h", i, d, exp_data[i]); failures++;
      end
    end
    // Refill, then overflow on the very edge a status read would clear ovf.
    press_key(1, 0);
    press_key(2, 0);
    press_key(3, 0);
    press_key(0, 3);
    press_read(1, 3, 4'd1, d);
    assertions++;
    if (d !== 8'h0C) begin
      $display("FAIL race_status: got %h want 0c", d); failures++;
    end
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h84) begin
      $display("FAIL race_ovf_kept: got %h want 84", d); failures++;
    end
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h04) begin
      $display("FAIL race_ovf_clear: got %h want 04", d); failures++;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] d;
    reset_dut();
    cols = 4'b0111;
    wait_ticks(3);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h11) begin
      $display("FAIL midhold_status: got %h want 11", d); failures++;
    end
    @(negedge clk);
    reset      = 1'b1;
    readEnable = 1'b1;
    address    = 4'd0;
    repeat (2) @(negedge clk);
    assertions++;
    if (dout !== 8'h00) begin
      $display("FAIL midhold_reset_read: got %h want 00", dout); failures++;
    end
    readEnable = 1'b0;
    reset      = 1'b0;
    wait_ticks(6);
    bus_read(4'd1, d);
    assertions++;
    if (d !== 8'h11) begin
      $display("FAIL midhold_repush: got %h want 11", d); failures++;
    end
    cols = 4'hF;
    wait_ticks(3);
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h83) begin
      $display("FAIL midhold_data: got %h want 83", d); failures++;
    end
    bus_read(4'd0, d);
    assertions++;
    if (d !== 8'h00) begin
      $display("FAIL midhold_empty: got %h want 00", d); failures++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan_order();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overflow();
    test_back_to_back();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per scan tick; legal range 2..65535.
REQ-002 Parameter DEBOUNCE_N, default 4: consecutive stable scan ticks required to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  the single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 rows  output  4  keypad row drive, active-low one-hot.
REQ-006 cols  input  4  keypad column sense, active-low, externally pulled up.
REQ-007 address  input  4  peripheral register select: 0 = key data, 1 = status; other values unmapped.
REQ-008 readEnable  input  1  one-cycle read strobe qualifying address.
REQ-009 dout  output  8  registered read data.

Function
REQ-010 A free-running divider SHALL assert one scan tick every SCAN_DIV clk cycles.
REQ-011 Scan state SHALL be held in row index r (0..3); rows SHALL equal ~(1<<r) at all times.
REQ-012 Candidate key: on a tick, a candidate SHALL exist only if exactly one cols bit is low; 0 or 2+ low bits SHALL mean no key.
REQ-013 Key code SHALL be {r[1:0], c[1:0]}, where c is the index of the low column.
REQ-014 The FSM SHALL have four states: SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-015 SCAN: on a tick with no candidate, r SHALL advance (3 wraps to 0); on a tick with a candidate, latch the code, clear the stability counter, and go to PRESS_DB with r frozen.
REQ-016 PRESS_DB: each tick with the same code SHALL increment the counter.
- Counter reaching DEBOUNCE_N: push the code to the FIFO and go to HELD.
- Any tick with a different code or no candidate: return to SCAN and advance r.
REQ-017 HELD: a tick with no candidate SHALL clear the counter and go to RELEASE_DB; r SHALL stay frozen.
REQ-018 RELEASE_DB: each tick with no candidate SHALL increment the counter.
- Counter reaching DEBOUNCE_N: go to SCAN and advance r.
- A tick with any candidate: return to HELD, with no new push.
REQ-019 Only one FIFO push SHALL occur per accepted press; holding a key SHALL not auto-repeat.
REQ-020 The FIFO SHALL be 4 entries of 4 bits, first-in first-out, with a 3-bit count 0..4.
REQ-021 A push when count==4 and no pop in the same cycle SHALL drop the code and set sticky bit ovf.
REQ-022 A push and a pop in the same cycle SHALL both succeed, including when count==4; count is unchanged.
REQ-023 A read with readEnable=1 and address=0 SHALL load dout={nonempty,3'b000,head} on the next clk edge (1-cycle latency).
- Pop only if nonempty.
- Empty read returns 8'h00.
REQ-024 A read with address=1 SHALL load dout={ovf,2'b00,state[1:0],count[2:0]} on the next clk edge and clear ovf.
- A same-cycle overflow event wins over the clear: ovf stays 1.
REQ-025 State encoding SHALL be SCAN=0, PRESS_DB=1, HELD=2, RELEASE_DB=3.
REQ-026 On a cycle with readEnable=0 or an unmapped address, dout SHALL be 8'h00.

Reset
REQ-027 While reset=1, these SHALL be loaded on each clk edge: divider=0, r=0 (rows=4'b1110), state=SCAN, counter=0, FIFO count=0, ovf=0, dout=8'h00.
REQ-028 Reset mid-debounce or mid-hold SHALL discard the candidate; a key still held after reset SHALL be re-debounced and pushed once.
REQ-029 readEnable SHALL be ignored during reset.

Verification (SCAN_DIV=4, DEBOUNCE_N=2)
REQ-030 Scan order: idle cols=4'hF after reset -> rows sequence 1110, 1101, 1011, 0111, 1110, each held 4 clks.
REQ-031 Single press: cols=4'b1011 while rows=1101 for 3 ticks, then release for 3 ticks -> exactly one push; address-0 read returns 8'h86; a second read returns 8'h00.
REQ-032 Bounce: col low 1 tick, high 1 tick, low 3 ticks -> exactly one push, code 8'h80|code; no push during the glitch.
REQ-033 Ghost/multi-key: cols=4'b1100 on any row -> no push; scan keeps advancing.
REQ-034 Overflow: 5 distinct presses with no reads -> status read returns 8'h84 (ovf=1, count=4); the next status read returns 8'h04; FIFO holds the first 4 codes in order.
REQ-035 Full push+pop: count=4, the 5th press is accepted on the same cycle as an address-0 read -> read returns the oldest code; count stays 4; ovf stays 0.
